// File: rtl/dmem_pkg.sv
// Shared types and default sizing for the wait-state data memory.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } dmem_state_t;

  localparam int unsigned DMEM_DATA_W   = 16;
  localparam int unsigned DMEM_ADDR_W   = 13;
  localparam int unsigned DMEM_DEPTH    = 1024;
  localparam int unsigned DMEM_WAIT_CYC = 2;

  // Stored bit makes byte plus parity carry an even number of ones.
  function automatic logic even_par(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage with byte-lane writes and a registered read port.
// Optional per-lane even parity storage when DMEM_PARITY_EN is defined.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W = DMEM_DATA_W,
  parameter int unsigned DEPTH  = DMEM_DEPTH,
  localparam int unsigned NB    = DATA_W / 8,
  localparam int unsigned IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic              rd_clr,
  input  logic [IW-1:0]     adr,
  input  logic [NB-1:0]     be,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] q
`ifdef DMEM_PARITY_EN
  ,
  output logic [NB-1:0]     q_par
`endif
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (be[i]) mem[adr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Read register resets, storage does not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (rd_clr) begin
      q <= '0;
    end else if (rd_en) begin
      q <= mem[adr];
    end
  end

`ifdef DMEM_PARITY_EN
  logic [NB-1:0] par [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (be[i]) par[adr][i] <= even_par(wdata[8*i +: 8]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_par <= '0;
    end else if (rd_clr) begin
      q_par <= '0;
    end else if (rd_en) begin
      q_par <= par[adr];
    end
  end
`endif

endmodule

// File: rtl/wait_state_dmem.sv
// Data memory with a fixed number of wait states per access.
// Define DMEM_PARITY_EN to add per-lane parity storage and checking.
module wait_state_dmem
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W   = DMEM_DATA_W,
  parameter int unsigned ADDR_W   = DMEM_ADDR_W,
  parameter int unsigned DEPTH    = DMEM_DEPTH,
  parameter int unsigned WAIT_CYC = DMEM_WAIT_CYC
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req,
  input  logic                we,
  input  logic [ADDR_W-1:0]   adr,
  input  logic [DATA_W/8-1:0] be,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata,
  output logic                busy,
  output logic                ready,
  output logic                err
);

  localparam int unsigned NB      = DATA_W / 8;
  localparam int unsigned IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [3:0]  WAIT_L  = 4'(WAIT_CYC);

  dmem_state_t state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic        accept, access;

  logic              we_q;
  logic [ADDR_W-1:0] adr_q;
  logic [NB-1:0]     be_q;
  logic [DATA_W-1:0] wdata_q;
  logic              oor_q;
  logic              par_err;

  logic              acc_we;
  logic [ADDR_W-1:0] acc_adr;
  logic [NB-1:0]     acc_be;
  logic [DATA_W-1:0] acc_wdata;
  logic              acc_oor;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    accept   = 1'b0;
    access   = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          accept = 1'b1;
          cnt_nx = WAIT_L;
          if (WAIT_L == 4'd0) begin
            state_nx = DONE;
            access   = 1'b1;
          end else begin
            state_nx = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_nx = cnt - 4'd1;
        if (cnt <= 4'd1) begin
          state_nx = DONE;
          cnt_nx   = '0;
          access   = 1'b1;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      adr_q   <= '0;
      be_q    <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      we_q    <= we;
      adr_q   <= adr;
      be_q    <= be;
      wdata_q <= wdata;
    end
  end

  // With zero wait states the access coincides with the accept edge,
  // so the array is fed from the ports instead of the latches.
  always_comb begin
    if (state == IDLE) begin
      acc_we    = we;
      acc_adr   = adr;
      acc_be    = be;
      acc_wdata = wdata;
    end else begin
      acc_we    = we_q;
      acc_adr   = adr_q;
      acc_be    = be_q;
      acc_wdata = wdata_q;
    end
    acc_oor = ({1'b0, acc_adr} >= DEPTH_L);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oor_q <= 1'b0;
    end else if (access) begin
      oor_q <= acc_oor;
    end
  end

`ifdef DMEM_PARITY_EN
  logic          chk_q;
  logic [NB-1:0] q_par;
  logic [NB-1:0] par_calc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chk_q <= 1'b0;
    end else if (access) begin
      chk_q <= ~acc_we & ~acc_oor;
    end
  end

  always_comb begin
    par_calc = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      par_calc[i] = even_par(rdata[8*i +: 8]);
    end
  end

  assign par_err = chk_q & (|(par_calc ^ q_par));
`else
  assign par_err = 1'b0;
`endif

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (access & acc_we & ~acc_oor),
    .rd_en  (access & ~acc_we & ~acc_oor),
    .rd_clr (access & ~acc_we & acc_oor),
    .adr    (acc_adr[IW-1:0]),
    .be     (acc_be),
    .wdata  (acc_wdata),
    .q      (rdata)
`ifdef DMEM_PARITY_EN
    ,
    .q_par  (q_par)
`endif
  );

  assign busy  = (state != IDLE);
  assign ready = (state == DONE);
  assign err   = (state == DONE) & (oor_q | par_err);

endmodule

// File: doc/wait_state_dmem.md
WAIT_STATE_DMEM -- requirements
Module: wait_state_dmem

Interface
REQ-001 SHALL have parameter DATA_W, default 16, data word width; must be a multiple of 8.
REQ-002 SHALL have parameter ADDR_W, default 13, address width.
REQ-003 SHALL have parameter DEPTH, default 1024, number of words; DEPTH <= 2**ADDR_W.
REQ-004 SHALL have parameter WAIT_CYC, default 2, wait states per access; range 0..15.
REQ-005 SHALL have port clk, input, 1 bit, clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit, reset; asynchronous, active-high.
REQ-007 SHALL have port req, input, 1 bit, access request.
REQ-008 SHALL have port we, input, 1 bit: 1 = write, 0 = read.
REQ-009 SHALL have port adr, input, ADDR_W bits, word address.
REQ-010 SHALL have port be, input, DATA_W/8 bits, byte-lane write enables; bit i covers wdata[8i+7:8i].
REQ-011 SHALL have port wdata, input, DATA_W bits, write data.
REQ-012 SHALL have port rdata, output, DATA_W bits, registered read data.
REQ-013 SHALL have port busy, output, 1 bit, high while a transaction is in flight.
REQ-014 SHALL have port ready, output, 1 bit, one-cycle completion pulse.
REQ-015 SHALL have port err, output, 1 bit, error status; valid only while ready is high.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, DONE.
REQ-017 In IDLE with req=1, SHALL latch we, adr, be and wdata, load the wait counter with WAIT_CYC, and move to WAIT, or to DONE if WAIT_CYC=0.
REQ-018 WAIT SHALL decrement the counter each cycle and move to DONE on the edge where the counter reaches 0.
REQ-019 The array SHALL be accessed on the edge leaving the last wait cycle, so ready rises exactly WAIT_CYC+1 cycles after the accept edge.
REQ-020 DONE SHALL last exactly one cycle with ready=1, then return to IDLE; a new req is sampled no earlier than the following IDLE cycle.
REQ-021 busy SHALL be 1 in WAIT and DONE and 0 in IDLE.
REQ-022 req SHALL be ignored in WAIT and DONE, with no queueing.
REQ-023 A write SHALL update only lanes with be[i]=1; be=0 SHALL complete with ready and leave the array unchanged.
REQ-024 A read SHALL load rdata with the word at the latched adr; rdata SHALL hold until the next completed read, and writes SHALL NOT change rdata.
REQ-025 For latched adr >= DEPTH: no array write, rdata loaded with 0 on a read, err=1 during ready.
REQ-026 The access SHALL use the latched adr/wdata/be; input changes after the accept edge SHALL have no effect.

Reset
REQ-027 rst SHALL force state IDLE, counter 0, rdata 0, busy 0, ready 0 and err 0 immediately.
REQ-028 Array contents SHALL NOT be cleared by rst.
REQ-029 rst asserted during WAIT SHALL abort the transaction with no array write and no ready pulse.

Configuration
REQ-030 With macro DMEM_PARITY_EN defined, SHALL store one even-parity bit per byte lane, written with that lane.
REQ-031 With DMEM_PARITY_EN defined, a read SHALL recompute parity, set err=1 with ready on any lane mismatch, and still return the stored data.
REQ-032 With DMEM_PARITY_EN undefined, SHALL store no parity bits, and err SHALL reflect only the out-of-range condition.

Structure
REQ-033 Package dmem_pkg SHALL hold the FSM state enum type and the default parameter constants.
REQ-034 Sub-module dmem_array SHALL hold the storage, the byte-enable write and the synchronous read, plus the parity bits when DMEM_PARITY_EN is defined.
REQ-035 wait_state_dmem SHALL hold the FSM, the wait counter, the latches and the range/parity error logic.

Verification
REQ-036 Defaults: write adr=0, wdata=16'h000F, be=2'b11, then read adr=0 -> ready 3 cycles after each accept edge, rdata=16'h000F, err=0.
REQ-037 Byte lanes: write 16'hAAAA to adr 5 with be=2'b11, then write 16'h1234 with be=2'b01, then read adr 5 -> rdata=16'hAA34.
REQ-038 Out of range: read adr=1024 -> ready with err=1, rdata=0; write adr=1500 -> err=1 and no array entry changes.
REQ-039 Busy handling: pulse req during WAIT -> ignored, single ready pulse, busy high 3 cycles; with WAIT_CYC=0 -> ready on the cycle after accept.
REQ-040 Reset mid-operation: assert rst one cycle after a write to adr 7 is accepted -> no ready, adr 7 keeps its old value, all outputs 0.
REQ-041 With DMEM_PARITY_EN defined: force-flip one stored data bit at adr 3, then read adr 3 -> err=1 and the corrupted data is returned.
